// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control unit: state codes, opcode map,
// ALU function codes and the opcode classifier used by opcode_decoder.
package ctrl_pkg;

  localparam int OPCODE_W = 5;
  localparam int ALU_OP_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11001;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_ROR = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_ROL = 4'd7;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_ALU_R   = 3'd1,
    CLS_ALU_I   = 3'd2,
    CLS_NOP     = 3'd3,
    CLS_HALT    = 3'd4
  } op_class_t;

  typedef struct packed {
    op_class_t             cls;
    logic [ALU_OP_W-1:0]   alu_op;
  } op_info_t;

  function automatic op_info_t decode_opcode(input logic [OPCODE_W-1:0] opcode);
    op_info_t info;
    info.cls    = CLS_ILLEGAL;
    info.alu_op = ALU_ADD;
    case (opcode)
      OP_ADD:  begin info.cls = CLS_ALU_R; info.alu_op = ALU_ADD; end
      OP_SUB:  begin info.cls = CLS_ALU_R; info.alu_op = ALU_SUB; end
      OP_AND:  begin info.cls = CLS_ALU_R; info.alu_op = ALU_AND; end
      OP_OR:   begin info.cls = CLS_ALU_R; info.alu_op = ALU_OR;  end
      OP_SHL:  begin info.cls = CLS_ALU_R; info.alu_op = ALU_SHL; end
      OP_SHR:  begin info.cls = CLS_ALU_R; info.alu_op = ALU_SHR; end
      OP_ROR:  begin info.cls = CLS_ALU_R; info.alu_op = ALU_ROR; end
      OP_ROL:  begin info.cls = CLS_ALU_R; info.alu_op = ALU_ROL; end
      OP_ADDI: begin info.cls = CLS_ALU_I; info.alu_op = ALU_ADD; end
      OP_ANDI: begin info.cls = CLS_ALU_I; info.alu_op = ALU_AND; end
      OP_ORI:  begin info.cls = CLS_ALU_I; info.alu_op = ALU_OR;  end
      OP_NOP:  info.cls = CLS_NOP;
      OP_HALT: info.cls = CLS_HALT;
      default: info.cls = CLS_ILLEGAL;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational classifier for ir[31:27]: instruction class flags plus the
// ALU function code the sequencer drives during the execute state.
module opcode_decoder
  import ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic [OPW-1:0]  opcode,
  output logic            is_alu_r,
  output logic            is_alu_i,
  output logic            is_nop,
  output logic            is_halt,
  output logic            is_illegal,
  output logic [ALUW-1:0] alu_op
);

  op_info_t info;

  assign info       = decode_opcode(OPCODE_W'(opcode));
  assign is_alu_r   = (info.cls == CLS_ALU_R);
  assign is_alu_i   = (info.cls == CLS_ALU_I);
  assign is_nop     = (info.cls == CLS_NOP);
  assign is_halt    = (info.cls == CLS_HALT);
  assign is_illegal = (info.cls == CLS_ILLEGAL);
  assign alu_op     = ALUW'(info.alu_op);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state sequencer driving the datapath strobes (Moore outputs).
// Build option CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap to IDLE with a sticky flag.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic            mem_ready,
  input  logic [31:0]     ir,
  output logic            pc_out,
  output logic            mar_in,
  output logic            inc_pc,
  output logic            z_in,
  output logic            zlo_out,
  output logic            pc_in,
  output logic            read,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            ir_in,
  output logic            y_in,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            r_in,
  output logic            r_out,
  output logic            c_out,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal,
  output logic [3:0]      step
);

  state_t          state_reg, state_next;
  logic            is_alu_r, is_alu_i, is_nop, is_halt, is_illegal;
  logic [ALUW-1:0] dec_alu_op;
  logic            trap_illegal;

  opcode_decoder #(.OPW(OPW), .ALUW(ALUW)) u_opcode_decoder (
    .opcode    (ir[31 -: OPW]),
    .is_alu_r  (is_alu_r),
    .is_alu_i  (is_alu_i),
    .is_nop    (is_nop),
    .is_halt   (is_halt),
    .is_illegal(is_illegal),
    .alu_op    (dec_alu_op)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_reg, illegal_next;
  logic unused_bits;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) illegal_reg <= 1'b0;
    else        illegal_reg <= illegal_next;
  end

  // The flag survives the trap into IDLE and is dropped by the restarting start.
  always_comb begin
    illegal_next = illegal_reg;
    if (state_reg == ST_IDLE && start)          illegal_next = 1'b0;
    else if (state_reg == ST_T4 && is_illegal)  illegal_next = 1'b1;
  end

  assign trap_illegal = is_illegal;
  assign illegal      = illegal_reg;
  assign unused_bits  = ^{ir[31-OPW:0], is_nop};
`else
  logic unused_bits;
  assign trap_illegal = 1'b0;
  assign illegal      = 1'b0;
  assign unused_bits  = ^{ir[31-OPW:0], is_nop, is_illegal};
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   if (mem_ready) state_next = ST_T3;
      ST_T3:   state_next = ST_T4;
      ST_T4: begin
        if (is_alu_r || is_alu_i)        state_next = ST_T5;
        else if (is_halt || trap_illegal) state_next = ST_IDLE;
        else                              state_next = ST_T0; // nop, or untrapped illegal
      end
      ST_T5:   state_next = ST_T6;
      ST_T6:   state_next = ST_T0;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_out  = 1'b0;
    mar_in  = 1'b0;
    inc_pc  = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    pc_in   = 1'b0;
    read    = 1'b0;
    mdr_in  = 1'b0;
    mdr_out = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    gra     = 1'b0;
    grb     = 1'b0;
    grc     = 1'b0;
    r_in    = 1'b0;
    r_out   = 1'b0;
    c_out   = 1'b0;
    alu_op  = '0;
    case (state_reg)
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        zlo_out = 1'b1;
        pc_in   = 1'b1;
      end
      ST_T2: begin
        read   = 1'b1;
        mdr_in = 1'b1;
      end
      ST_T3: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T4: begin
        if (is_alu_r || is_alu_i) begin
          grb   = 1'b1;
          r_out = 1'b1;
          y_in  = 1'b1;
        end
      end
      ST_T5: begin
        z_in   = 1'b1;
        alu_op = dec_alu_op;
        // Second operand: register rc for ALU-R, sign-extended constant for ALU-I.
        if (is_alu_r) begin
          grc   = 1'b1;
          r_out = 1'b1;
        end else if (is_alu_i) begin
          c_out = 1'b1;
        end
      end
      ST_T6: begin
        zlo_out = 1'b1;
        gra     = 1'b1;
        r_in    = 1'b1;
      end
      default: ;
    endcase
  end

  assign run  = (state_reg != ST_IDLE);
  assign step = state_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer, plus hand sequences for
// the ALU opcode map and an asynchronous reset taken mid-instruction.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, read, mdr_in, mdr_out;
  logic ir_in, y_in, gra, grb, grc, r_in, r_out, c_out, run, illegal;
  logic [3:0]  alu_op;
  logic [3:0]  step;
  logic [16:0] strobes;

  int n_checks = 0;
  int n_errors = 0;

  control_sequencer #(.OPW(5), .ALUW(4)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlo_out(zlo_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .gra(gra), .grb(grb),
    .grc(grc), .r_in(r_in), .r_out(r_out), .c_out(c_out), .alu_op(alu_op),
    .run(run), .illegal(illegal), .step(step)
  );

  assign strobes = {pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, read, mdr_in,
                    mdr_out, ir_in, y_in, gra, grb, grc, r_in, r_out, c_out};

  localparam logic [16:0] B_PC_OUT  = 17'h10000;
  localparam logic [16:0] B_MAR_IN  = 17'h08000;
  localparam logic [16:0] B_INC_PC  = 17'h04000;
  localparam logic [16:0] B_Z_IN    = 17'h02000;
  localparam logic [16:0] B_ZLO_OUT = 17'h01000;
  localparam logic [16:0] B_PC_IN   = 17'h00800;
  localparam logic [16:0] B_READ    = 17'h00400;
  localparam logic [16:0] B_MDR_IN  = 17'h00200;
  localparam logic [16:0] B_MDR_OUT = 17'h00100;
  localparam logic [16:0] B_IR_IN   = 17'h00080;
  localparam logic [16:0] B_Y_IN    = 17'h00040;
  localparam logic [16:0] B_GRA     = 17'h00020;
  localparam logic [16:0] B_GRB     = 17'h00010;
  localparam logic [16:0] B_GRC     = 17'h00008;
  localparam logic [16:0] B_R_IN    = 17'h00004;
  localparam logic [16:0] B_R_OUT   = 17'h00002;
  localparam logic [16:0] B_C_OUT   = 17'h00001;

  localparam logic [16:0] M_NONE = 17'h0;
  localparam logic [16:0] M_T0   = B_PC_OUT | B_MAR_IN | B_INC_PC | B_Z_IN;
  localparam logic [16:0] M_T1   = B_ZLO_OUT | B_PC_IN;
  localparam logic [16:0] M_T2   = B_READ | B_MDR_IN;
  localparam logic [16:0] M_T3   = B_MDR_OUT | B_IR_IN;
  localparam logic [16:0] M_T4A  = B_GRB | B_R_OUT | B_Y_IN;
  localparam logic [16:0] M_T5R  = B_Z_IN | B_GRC | B_R_OUT;
  localparam logic [16:0] M_T5I  = B_Z_IN | B_C_OUT;
  localparam logic [16:0] M_T6   = B_ZLO_OUT | B_GRA | B_R_IN;

  localparam logic [31:0] IR_SHL  = 32'h3800_0000;
  localparam logic [31:0] IR_ADDI = 32'h6000_0005;
  localparam logic [31:0] IR_NOP  = 32'hC000_0000;
  localparam logic [31:0] IR_HALT = 32'hC800_0000;
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;

  typedef struct {
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic [3:0]  step;
    logic [16:0] strobes;
    logic [3:0]  alu_op;
    logic        run;
    logic        illegal;
  } vec_t;

  vec_t vecs[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic add(input logic st, input logic mr, input logic [31:0] i,
                     input logic [3:0] s, input logic [16:0] m,
                     input logic [3:0] a, input logic r, input logic il);
    vec_t v;
    v.start = st; v.mem_ready = mr; v.ir = i; v.step = s;
    v.strobes = m; v.alu_op = a; v.run = r; v.illegal = il;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] s, input logic [16:0] m,
                           input logic [3:0] a, input logic r, input logic il);
    check({tag, ".step"},    32'(step),    32'(s));
    check({tag, ".strobes"}, 32'(strobes), 32'(m));
    check({tag, ".alu_op"},  32'(alu_op),  32'(a));
    check({tag, ".run"},     32'(run),     32'(r));
    check({tag, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [4:0] op_list  [10];
  logic [3:0] alu_list [10];
  logic       imm_list [10];

  initial begin
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;

    // Instruction stream: idle hold, shl, shl with a 3-cycle memory stall,
    // addi, nop (start ignored), halt + restart, illegal opcode.
    add(0,1,IR_SHL, 0,M_NONE,0,0,0);
    add(1,1,IR_SHL, 1,M_T0,0,1,0);
    add(0,1,IR_SHL, 2,M_T1,0,1,0);
    add(0,1,IR_SHL, 3,M_T2,0,1,0);
    add(0,1,IR_SHL, 4,M_T3,0,1,0);
    add(0,1,IR_SHL, 5,M_T4A,0,1,0);
    add(0,1,IR_SHL, 6,M_T5R,4,1,0);
    add(0,1,IR_SHL, 7,M_T6,0,1,0);
    add(0,1,IR_SHL, 1,M_T0,0,1,0);
    add(0,1,IR_SHL, 2,M_T1,0,1,0);
    add(0,0,IR_SHL, 3,M_T2,0,1,0);
    add(0,0,IR_SHL, 3,M_T2,0,1,0);
    add(0,0,IR_SHL, 3,M_T2,0,1,0);
    add(0,0,IR_SHL, 3,M_T2,0,1,0);
    add(0,1,IR_SHL, 4,M_T3,0,1,0);
    add(0,1,IR_SHL, 5,M_T4A,0,1,0);
    add(0,1,IR_SHL, 6,M_T5R,4,1,0);
    add(0,1,IR_SHL, 7,M_T6,0,1,0);
    add(0,1,IR_SHL, 1,M_T0,0,1,0);
    add(0,1,IR_ADDI,2,M_T1,0,1,0);
    add(0,1,IR_ADDI,3,M_T2,0,1,0);
    add(0,1,IR_ADDI,4,M_T3,0,1,0);
    add(0,1,IR_ADDI,5,M_T4A,0,1,0);
    add(0,1,IR_ADDI,6,M_T5I,0,1,0);
    add(0,1,IR_ADDI,7,M_T6,0,1,0);
    add(0,1,IR_ADDI,1,M_T0,0,1,0);
    add(1,1,IR_NOP, 2,M_T1,0,1,0);
    add(1,1,IR_NOP, 3,M_T2,0,1,0);
    add(0,1,IR_NOP, 4,M_T3,0,1,0);
    add(0,1,IR_NOP, 5,M_NONE,0,1,0);
    add(0,1,IR_NOP, 1,M_T0,0,1,0);
    add(0,1,IR_HALT,2,M_T1,0,1,0);
    add(0,1,IR_HALT,3,M_T2,0,1,0);
    add(0,1,IR_HALT,4,M_T3,0,1,0);
    add(0,1,IR_HALT,5,M_NONE,0,1,0);
    add(0,1,IR_HALT,0,M_NONE,0,0,0);
    add(0,1,IR_HALT,0,M_NONE,0,0,0);
    add(1,1,IR_HALT,1,M_T0,0,1,0);
    add(0,1,IR_ILL, 2,M_T1,0,1,0);
    add(0,1,IR_ILL, 3,M_T2,0,1,0);
    add(0,1,IR_ILL, 4,M_T3,0,1,0);
    add(0,1,IR_ILL, 5,M_NONE,0,1,0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    add(0,1,IR_ILL, 0,M_NONE,0,0,1);
    add(0,1,IR_ILL, 0,M_NONE,0,0,1);
    add(0,1,IR_ILL, 0,M_NONE,0,0,1);
    add(1,1,IR_ILL, 1,M_T0,0,1,0);
`else
    add(0,1,IR_ILL, 1,M_T0,0,1,0);
`endif

    op_list[0] = 5'b00011; alu_list[0] = 4'd0; imm_list[0] = 1'b0;
    op_list[1] = 5'b00100; alu_list[1] = 4'd1; imm_list[1] = 1'b0;
    op_list[2] = 5'b00101; alu_list[2] = 4'd2; imm_list[2] = 1'b0;
    op_list[3] = 5'b00110; alu_list[3] = 4'd3; imm_list[3] = 1'b0;
    op_list[4] = 5'b00111; alu_list[4] = 4'd4; imm_list[4] = 1'b0;
    op_list[5] = 5'b01000; alu_list[5] = 4'd5; imm_list[5] = 1'b0;
    op_list[6] = 5'b01001; alu_list[6] = 4'd6; imm_list[6] = 1'b0;
    op_list[7] = 5'b01010; alu_list[7] = 4'd7; imm_list[7] = 1'b0;
    op_list[8] = 5'b01101; alu_list[8] = 4'd2; imm_list[8] = 1'b1;
    op_list[9] = 5'b01110; alu_list[9] = 4'd3; imm_list[9] = 1'b1;

    #1;
    check_all("reset", 4'd0, M_NONE, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    clear = 1'b1;

    foreach (vecs[i]) begin
      start     = vecs[i].start;
      mem_ready = vecs[i].mem_ready;
      ir        = vecs[i].ir;
      tick();
      $display("vec %0d: step=%0d strobes=%05h alu_op=%0d run=%0b illegal=%0b",
               i, step, strobes, alu_op, run, illegal);
      check_all($sformatf("vec%0d", i), vecs[i].step, vecs[i].strobes,
                vecs[i].alu_op, vecs[i].run, vecs[i].illegal);
    end

    // Opcode map: one full instruction per ALU opcode, starting from T0.
    start = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ir = {op_list[k], 27'h0};
      for (int t = 0; t < 4; t++) tick();
      check_all($sformatf("op%0d.t4", k), 4'd5, M_T4A, 4'd0, 1'b1, 1'b0);
      tick();
      check_all($sformatf("op%0d.t5", k), 4'd6, imm_list[k] ? M_T5I : M_T5R,
                alu_list[k], 1'b1, 1'b0);
      tick();
      tick();
      $display("op %0d: opcode=%05b alu_op_in_t5 checked, back at step=%0d",
               k, op_list[k], step);
      check($sformatf("op%0d.t0", k), 32'(step), 32'd1);
    end

    // Asynchronous reset in the middle of T5.
    ir = IR_SHL;
    for (int t = 0; t < 5; t++) tick();
    check("pre_reset.step", 32'(step), 32'd6);
    @(negedge clock);
    clear = 1'b0;
    #1;
    $display("reset mid-T5: step=%0d strobes=%05h run=%0b", step, strobes, run);
    check_all("mid_reset", 4'd0, M_NONE, 4'd0, 1'b0, 1'b0);
    tick();
    check_all("held_reset", 4'd0, M_NONE, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    clear = 1'b1;
    tick();
    check_all("post_reset_idle", 4'd0, M_NONE, 4'd0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("post_reset_start", 4'd1, M_T0, 4'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
